instruction_cache: RTL and testbench

- Direct-mapped, read-only instruction cache. Serves the responder side of the fetch interface: the fetch stage presents a word address, and the cache returns a one-cycle ready pulse with the 32-bit instruction.
- Sits between the instruction fetch stage and the memory controller.
- On a miss it refills the whole line word-by-word from the memory controller, then answers.
- A ROB clear aborts any in-flight request.

---
 rtl/instruction_cache.sv | 164 ++++++++++++++++
 tb/tb_instruction_cache.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the fetch stage and the memory controller.
// Misses refill the whole line word-by-word from word 0; a ROB clear aborts any in-flight request.
module instruction_cache #(
  parameter int INDEX_BITS    = 4,
  parameter int WORD_SEL_BITS = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        valid_in,
  input  logic [31:0] addr_in,
  input  logic        clear_in,
  output logic        inst_ready_out,
  output logic [31:0] inst_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_data_in
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << WORD_SEL_BITS;
  localparam int TAG_LSB  = INDEX_BITS + WORD_SEL_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [31:2]                req_addr_q, req_addr_d;
  logic [WORD_SEL_BITS-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]           valid_q, valid_d;
  logic                       inst_ready_q, inst_ready_d;
  logic [31:0]                inst_q, inst_d;
  logic                       mem_req_q, mem_req_d;
  logic [31:0]                mem_addr_q, mem_addr_d;
  logic [TAG_BITS-1:0]        tag_q  [LINES];
  logic [31:0]                data_q [LINES*WORDS];

  logic [WORD_SEL_BITS-1:0]   in_word_s, req_word_s;
  logic [INDEX_BITS-1:0]      in_index_s, req_index_s;
  logic [TAG_BITS-1:0]        in_tag_s, req_tag_s;
  logic                       hit_s, fill_s, last_word_s;
  logic                       data_we_s, tag_we_s;

  assign in_word_s   = addr_in[WORD_SEL_BITS+1:2];
  assign in_index_s  = addr_in[TAG_LSB-1:WORD_SEL_BITS+2];
  assign in_tag_s    = addr_in[31:TAG_LSB];
  assign req_word_s  = req_addr_q[WORD_SEL_BITS+1:2];
  assign req_index_s = req_addr_q[TAG_LSB-1:WORD_SEL_BITS+2];
  assign req_tag_s   = req_addr_q[31:TAG_LSB];

  assign hit_s       = valid_q[in_index_s] && (tag_q[in_index_s] == in_tag_s);
  // A beat only counts while the request is still being asserted.
  assign fill_s      = mem_req_q && mem_ready_in;
  assign last_word_s = (cnt_q == {WORD_SEL_BITS{1'b1}});

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      req_addr_q   <= 30'd0;
      cnt_q        <= {WORD_SEL_BITS{1'b0}};
      valid_q      <= {LINES{1'b0}};
      inst_ready_q <= 1'b0;
      inst_q       <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && data_we_s) begin
      data_q[{req_index_s, cnt_q}] <= mem_data_in;
    end
    if (!rst_in && rdy_in && tag_we_s) begin
      tag_q[req_index_s] <= req_tag_s;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (valid_in && !hit_s) state_d = REFILL;
        REFILL:  if (fill_s && last_word_s) state_d = RESPOND;
        RESPOND: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_addr_d   = req_addr_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    inst_ready_d = 1'b0;
    inst_d       = inst_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    data_we_s    = 1'b0;
    tag_we_s     = 1'b0;
    if (clear_in) begin
      mem_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in && hit_s) begin
            inst_ready_d = 1'b1;
            inst_d       = data_q[{in_index_s, in_word_s}];
          end else if (valid_in) begin
            req_addr_d          = addr_in[31:2];
            valid_d[in_index_s] = 1'b0;
            cnt_d               = {WORD_SEL_BITS{1'b0}};
            mem_req_d           = 1'b1;
            mem_addr_d          = {addr_in[31:WORD_SEL_BITS+2], {(WORD_SEL_BITS+2){1'b0}}};
          end else begin
            mem_req_d = 1'b0;
          end
        end
        REFILL: begin
          if (fill_s) begin
            data_we_s  = 1'b1;
            cnt_d      = cnt_q + WORD_SEL_BITS'(1);
            mem_addr_d = mem_addr_q + 32'd4;
            if (last_word_s) begin
              tag_we_s             = 1'b1;
              valid_d[req_index_s] = 1'b1;
              mem_req_d            = 1'b0;
              inst_ready_d         = 1'b1;
              // The requested word may be the one arriving right now.
              inst_d = (req_word_s == cnt_q) ? mem_data_in : data_q[{req_index_s, req_word_s}];
            end else begin
              mem_req_d = 1'b1;
            end
          end else begin
            mem_req_d = 1'b1;
          end
        end
        RESPOND: mem_req_d = 1'b0;
        default: mem_req_d = 1'b0;
      endcase
    end
  end

  assign inst_ready_out = inst_ready_q;
  assign inst_out       = inst_q;
  assign mem_req_out    = mem_req_q;
  assign mem_addr_out   = mem_addr_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache: cold miss, hits, conflict,
// abort, rdy freeze and clear priority, each with hand-computed expectations.
module tb_instruction_cache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, valid_in, clear_in, mem_ready_in;
  logic [31:0] addr_in, mem_data_in;
  logic        inst_ready_out, mem_req_out;
  logic [31:0] inst_out, mem_addr_out;

  int total = 0;
  int bad   = 0;

  instruction_cache #(.INDEX_BITS(4), .WORD_SEL_BITS(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .valid_in       (valid_in),
    .addr_in        (addr_in),
    .clear_in       (clear_in),
    .inst_ready_out (inst_ready_out),
    .inst_out       (inst_out),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_ready_in   (mem_ready_in),
    .mem_data_in    (mem_data_in)
  );

  always #5 clk_in = ~clk_in;

  // Backing memory contents: line 0 holds 0x11..0x44, everything else is 0xC000_0000 | addr.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      32'hC:   return 32'h0000_0044;
      default: return 32'hC000_0000 | a;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; valid_in = 1'b0; clear_in = 1'b0;
    addr_in = 32'd0; mem_ready_in = 1'b0; mem_data_in = 32'd0;
    tick(); tick();
    rst_in = 1'b0;
    total++; if (inst_ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", inst_ready_out); end
    total++; if (inst_out !== 32'd0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst_out); end
    total++; if (mem_req_out !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req_out); end
    total++; if (mem_addr_out !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr_out); end
  endtask

  task automatic test_cold_miss();
    valid_in = 1'b1; addr_in = 32'h0;
    tick();
    total++; if (mem_req_out !== 1'b1) begin bad++; $display("FAIL cold_req got=%b exp=1", mem_req_out); end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_addr_out !== 32'(i * 4)) begin bad++; $display("FAIL cold_addr%0d got=%h exp=%h", i, mem_addr_out, 32'(i * 4)); end
      total++; if (inst_ready_out !== 1'b0) begin bad++; $display("FAIL cold_early_ready%0d got=%b exp=0", i, inst_ready_out); end
      mem_ready_in = 1'b1; mem_data_in = mem_word(32'(i * 4));
      tick();
      mem_ready_in = 1'b0;
    end
    valid_in = 1'b0;
    total++; if (inst_ready_out !== 1'b1) begin bad++; $display("FAIL cold_ready got=%b exp=1", inst_ready_out); end
    total++; if (inst_out !== 32'h11) begin bad++; $display("FAIL cold_inst got=%h exp=00000011", inst_out); end
    total++; if (mem_req_out !== 1'b0) begin bad++; $display("FAIL cold_req_drop got=%b exp=0", mem_req_out); end
    tick();
    total++; if (inst_ready_out !== 1'b0) begin bad++; $display("FAIL cold_pulse got=%b exp=0", inst_ready_out); end
  endtask

  task automatic test_hits();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h22; exp_w[1] = 32'h33; exp_w[2] = 32'h44;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; addr_in = 32'(4 + 4 * i);
      tick();
      total++; if (inst_ready_out !== 1'b1 || inst_out !== exp_w[i]) begin bad++; $display("FAIL hit%0d got=%b/%h exp=1/%h", i, inst_ready_out, inst_out, exp_w[i]); end
      total++; if (mem_req_out !== 1'b0) begin bad++; $display("FAIL hit_req%0d got=%b exp=0", i, mem_req_out); end
    end
    valid_in = 1'b0;
    tick();
    total++; if (inst_ready_out !== 1'b0 || inst_out !== 32'h44) begin bad++; $display("FAIL hit_hold got=%b/%h exp=0/00000044", inst_ready_out, inst_out); end
  endtask

  task automatic test_conflict();
    valid_in = 1'b1; addr_in = 32'h108;
    tick();
    total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h100) begin bad++; $display("FAIL conf_miss got=%b/%h exp=1/00000100", mem_req_out, mem_addr_out); end
    for (int i = 0; i < 4; i++) begin
      mem_ready_in = 1'b1; mem_data_in = mem_word(32'h100 + 32'(4 * i));
      tick();
    end
    mem_ready_in = 1'b0; valid_in = 1'b0;
    total++; if (inst_ready_out !== 1'b1 || inst_out !== 32'hC000_0108) begin bad++; $display("FAIL conf_inst got=%b/%h exp=1/c0000108", inst_ready_out, inst_out); end
    tick();
    valid_in = 1'b1; addr_in = 32'h0;
    tick();
    total++; if (inst_ready_out !== 1'b0 || mem_req_out !== 1'b1 || mem_addr_out !== 32'h0) begin bad++; $display("FAIL conf_remiss got=%b/%b/%h exp=0/1/00000000", inst_ready_out, mem_req_out, mem_addr_out); end
    for (int i = 0; i < 4; i++) begin
      mem_ready_in = 1'b1; mem_data_in = mem_word(32'(4 * i));
      tick();
    end
    mem_ready_in = 1'b0; valid_in = 1'b0;
    total++; if (inst_ready_out !== 1'b1 || inst_out !== 32'h11) begin bad++; $display("FAIL conf_back got=%b/%h exp=1/00000011", inst_ready_out, inst_out); end
    tick();
  endtask

  task automatic test_abort();
    valid_in = 1'b1; addr_in = 32'h40;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_ready_in = 1'b1; mem_data_in = mem_word(32'h40 + 32'(4 * i));
      tick();
    end
    total++; if (mem_addr_out !== 32'h48) begin bad++; $display("FAIL abort_addr got=%h exp=00000048", mem_addr_out); end
    clear_in = 1'b1; mem_data_in = 32'hBAD0_0048;
    tick();
    clear_in = 1'b0;
    total++; if (mem_req_out !== 1'b0 || inst_ready_out !== 1'b0) begin bad++; $display("FAIL abort_clear got=%b/%b exp=0/0", mem_req_out, inst_ready_out); end
    mem_data_in = 32'hBAD0_004C;
    tick();
    mem_ready_in = 1'b0;
    total++; if (mem_req_out !== 1'b0 || inst_ready_out !== 1'b0) begin bad++; $display("FAIL abort_stray got=%b/%b exp=0/0", mem_req_out, inst_ready_out); end
    valid_in = 1'b1; addr_in = 32'h40;
    tick();
    total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h40) begin bad++; $display("FAIL abort_rereq got=%b/%h exp=1/00000040", mem_req_out, mem_addr_out); end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_addr_out !== 32'h40 + 32'(4 * i)) begin bad++; $display("FAIL abort_seq%0d got=%h exp=%h", i, mem_addr_out, 32'h40 + 32'(4 * i)); end
      mem_ready_in = 1'b1; mem_data_in = mem_word(32'h40 + 32'(4 * i));
      tick();
    end
    mem_ready_in = 1'b0; valid_in = 1'b0;
    total++; if (inst_ready_out !== 1'b1 || inst_out !== 32'hC000_0040) begin bad++; $display("FAIL abort_inst got=%b/%h exp=1/c0000040", inst_ready_out, inst_out); end
    tick();
  endtask

  task automatic test_freeze();
    valid_in = 1'b1; addr_in = 32'h80;
    tick();
    valid_in = 1'b0;
    mem_ready_in = 1'b1; mem_data_in = mem_word(32'h80);
    tick();
    rdy_in = 1'b0; mem_data_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h84) begin bad++; $display("FAIL freeze%0d got=%b/%h exp=1/00000084", i, mem_req_out, mem_addr_out); end
    end
    rdy_in = 1'b1; mem_ready_in = 1'b0;
    tick();
    total++; if (mem_addr_out !== 32'h84) begin bad++; $display("FAIL freeze_resume got=%h exp=00000084", mem_addr_out); end
    for (int i = 1; i < 4; i++) begin
      mem_ready_in = 1'b1; mem_data_in = mem_word(32'h80 + 32'(4 * i));
      tick();
    end
    mem_ready_in = 1'b0;
    total++; if (inst_ready_out !== 1'b1 || inst_out !== 32'hC000_0080) begin bad++; $display("FAIL freeze_inst got=%b/%h exp=1/c0000080", inst_ready_out, inst_out); end
    tick();
    valid_in = 1'b1; addr_in = 32'h84;
    tick();
    valid_in = 1'b0;
    total++; if (inst_ready_out !== 1'b1 || inst_out !== 32'hC000_0084) begin bad++; $display("FAIL freeze_word1 got=%b/%h exp=1/c0000084", inst_ready_out, inst_out); end
  endtask

  task automatic test_clear_priority();
    valid_in = 1'b1; clear_in = 1'b1; addr_in = 32'h4;
    tick();
    valid_in = 1'b0; clear_in = 1'b0;
    total++; if (inst_ready_out !== 1'b0 || mem_req_out !== 1'b0) begin bad++; $display("FAIL clrpri got=%b/%b exp=0/0", inst_ready_out, mem_req_out); end
    total++; if (inst_out !== 32'hC000_0084) begin bad++; $display("FAIL clrpri_hold got=%h exp=c0000084", inst_out); end
    tick();
    valid_in = 1'b1; addr_in = 32'h4;
    tick();
    valid_in = 1'b0;
    total++; if (inst_ready_out !== 1'b1 || inst_out !== 32'h22) begin bad++; $display("FAIL clrpri_idle got=%b/%h exp=1/00000022", inst_ready_out, inst_out); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_abort();
    test_freeze();
    test_clear_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
